// File: rtl/palette_if.sv
// Palette controller bus bundle: ROM preload, pixel lookup and CPU access signals.
// master = surrounding system, slave = palette_ctrl; PALETTE_GRAYSCALE_EN adds the grayscale input.
interface palette_if #(
  parameter int CW = 6
);
  logic [4:0]    rom_addr;
  logic [7:0]    rom_dout;
  logic          init_done;
  logic          pix_valid;
  logic [4:0]    pix_idx;
  logic          pix_color_valid;
  logic [CW-1:0] pix_color;
  logic          cpu_req;
  logic          cpu_we;
  logic [4:0]    cpu_addr;
  logic [CW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic          cpu_rvalid;
  logic [CW-1:0] cpu_rdata;
`ifdef PALETTE_GRAYSCALE_EN
  logic          grayscale;

  modport master (
    input  rom_addr, init_done, pix_color_valid, pix_color, cpu_ready, cpu_rvalid, cpu_rdata,
    output rom_dout, pix_valid, pix_idx, cpu_req, cpu_we, cpu_addr, cpu_wdata, grayscale
  );
  modport slave (
    output rom_addr, init_done, pix_color_valid, pix_color, cpu_ready, cpu_rvalid, cpu_rdata,
    input  rom_dout, pix_valid, pix_idx, cpu_req, cpu_we, cpu_addr, cpu_wdata, grayscale
  );
`else
  modport master (
    input  rom_addr, init_done, pix_color_valid, pix_color, cpu_ready, cpu_rvalid, cpu_rdata,
    output rom_dout, pix_valid, pix_idx, cpu_req, cpu_we, cpu_addr, cpu_wdata
  );
  modport slave (
    output rom_addr, init_done, pix_color_valid, pix_color, cpu_ready, cpu_rvalid, cpu_rdata,
    input  rom_dout, pix_valid, pix_idx, cpu_req, cpu_we, cpu_addr, cpu_wdata
  );
`endif
endinterface

// File: rtl/palette_ctrl.sv
// NES palette RAM: preloads 32 entries from ROM after reset, then serves pixel (priority) and CPU ports.
// Pixel/CPU reads return one cycle later; optional PALETTE_GRAYSCALE_EN masks pixel colours to 6'h30.
module palette_ctrl #(
  parameter int NUM_ENTRIES = 32,
  parameter int CW          = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  palette_if.slave bus
);
  localparam int AW = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {LOAD, FLUSH, RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] load_cnt_q, load_cnt_d;
  logic [4:0]    ld_addr_q, ld_addr_d;
  logic          ld_wr_q, ld_wr_d;
  logic          pix_vld_q, pix_vld_d;
  logic [CW-1:0] pix_color_q, pix_color_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [CW-1:0] cpu_rdata_q, cpu_rdata_d;

  logic [CW-1:0] mem_q [32];
  logic          mem_we;
  logic [4:0]    mem_waddr;
  logic [CW-1:0] mem_wdata;

  logic [4:0]    rom_addr;
  logic          cpu_ready;
  logic [CW-1:0] pix_mask;
  logic          unused_rom_hi;

  // Sprite backdrop slots 0x10/0x14/0x18/0x1C alias the background entries below them.
  function automatic logic [4:0] mirror(input logic [4:0] a);
    return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
  endfunction

  assign unused_rom_hi = ^bus.rom_dout[7:CW];

`ifdef PALETTE_GRAYSCALE_EN
  assign pix_mask = bus.grayscale ? CW'(6'h30) : '1;
`else
  assign pix_mask = '1;
`endif

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    ld_addr_d    = ld_addr_q;
    ld_wr_d      = 1'b0;
    pix_vld_d    = 1'b0;
    pix_color_d  = pix_color_q;
    cpu_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    rom_addr     = 5'd0;
    cpu_ready    = 1'b0;
    // Preload write trails the ROM address by one cycle, covering FLUSH as well.
    mem_we       = ld_wr_q;
    mem_waddr    = mirror(ld_addr_q);
    mem_wdata    = bus.rom_dout[CW-1:0];

    case (state_q)
      LOAD: begin
        rom_addr   = 5'(load_cnt_q);
        load_cnt_d = load_cnt_q + 1'b1;
        ld_addr_d  = 5'(load_cnt_q);
        ld_wr_d    = 1'b1;
        if (load_cnt_q == AW'(NUM_ENTRIES - 1)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      RUN: begin
        cpu_ready = !bus.pix_valid;
        if (bus.pix_valid) begin
          pix_vld_d   = 1'b1;
          pix_color_d = mem_q[mirror(bus.pix_idx)] & pix_mask;
        end
        if (bus.cpu_req && cpu_ready) begin
          if (bus.cpu_we) begin
            mem_we    = 1'b1;
            mem_waddr = mirror(bus.cpu_addr);
            mem_wdata = bus.cpu_wdata;
          end else begin
            cpu_rvalid_d = 1'b1;
            cpu_rdata_d  = mem_q[mirror(bus.cpu_addr)];
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      load_cnt_q   <= '0;
      ld_addr_q    <= '0;
      ld_wr_q      <= 1'b0;
      pix_vld_q    <= 1'b0;
      pix_color_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      ld_addr_q    <= ld_addr_d;
      ld_wr_q      <= ld_wr_d;
      pix_vld_q    <= pix_vld_d;
      pix_color_q  <= pix_color_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  // Contents are undefined after reset; the preload rewrites every entry.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.rom_addr        = rom_addr;
  assign bus.init_done       = (state_q == RUN);
  assign bus.cpu_ready       = cpu_ready;
  assign bus.pix_color_valid = pix_vld_q;
  assign bus.pix_color       = pix_color_q;
  assign bus.cpu_rvalid      = cpu_rvalid_q;
  assign bus.cpu_rdata       = cpu_rdata_q;
endmodule

// File: tb/tb_palette_ctrl.sv
// Directed bench for palette_ctrl: preload timing, pixel/CPU reads, mirroring, contention, mid-load reset.
module tb_palette_ctrl;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] rom     [32];
  logic [5:0] exp_ram [32];

  palette_if #(.CW(6)) bus ();

  palette_ctrl #(.NUM_ENTRIES(32), .CW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM: data appears one clock after the address.
  always @(posedge clk) bus.rom_dout <= rom[bus.rom_addr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] tb_mirror(input logic [4:0] a);
    return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
  endfunction

  task automatic build_exp();
    for (int i = 0; i < 32; i++) exp_ram[tb_mirror(5'(i))] = rom[i][5:0];
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_init_done"}, bus.init_done, 0);
    chk({tag, "_rom_addr"}, bus.rom_addr, 0);
    chk({tag, "_pix_cv"}, bus.pix_color_valid, 0);
    chk({tag, "_pix_color"}, bus.pix_color, 0);
    chk({tag, "_cpu_rvalid"}, bus.cpu_rvalid, 0);
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
    chk({tag, "_cpu_ready"}, bus.cpu_ready, 0);
  endtask

  // Releases reset and runs the preload with pixel and CPU requests pending.
  task automatic do_load();
    int n   = 0;
    int bad = 0;
    bus.pix_valid = 1'b1;
    bus.pix_idx   = 5'h05;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 5'h0D;
    tick();
    rst_n = 1'b1;
    while (!bus.init_done && n < 100) begin
      tick();
      n++;
      if (n <= 31) chk("load_rom_addr", bus.rom_addr, n);
      if (!bus.init_done && (bus.cpu_ready || bus.pix_color_valid || bus.cpu_rvalid)) bad++;
      bus.pix_valid = (n < 16);
      bus.cpu_req   = (n < 32);
    end
    chk("init_edges", n, 33);
    chk("load_no_resp", bad, 0);
    chk("rom_addr_run", bus.rom_addr, 0);
    tick();
    chk("stale_pix_cv", bus.pix_color_valid, 0);
    chk("stale_rvalid", bus.cpu_rvalid, 0);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_idx   = 5'(i);
      tick();
      chk(tag, bus.pix_color, exp_ram[tb_mirror(5'(i))]);
    end
    chk({tag, "_cv"}, bus.pix_color_valid, 1);
    bus.pix_valid = 1'b0;
    tick();
  endtask

  initial begin
    rom = '{8'h0F, 8'h29, 8'hDA, 8'h0F, 8'h0F, 8'h36, 8'h17, 8'h0F,
            8'h01, 8'h30, 8'h21, 8'h0F, 8'h0F, 8'h27, 8'h17, 8'h0F,
            8'h22, 8'h16, 8'h27, 8'h18, 8'h22, 8'h1A, 8'h30, 8'h27,
            8'h22, 8'h16, 8'h30, 8'h27, 8'h22, 8'h0F, 8'h76, 8'h17};
    rst_n         = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_idx   = 5'h00;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 5'h00;
    bus.cpu_wdata = 6'h00;
`ifdef PALETTE_GRAYSCALE_EN
    bus.grayscale = 1'b0;
`endif
    tick();
    check_reset_vals("rst");

    do_load();

    // Back-to-back pixel lookups with hand-computed colours.
    bus.pix_valid = 1'b1;
    bus.pix_idx   = 5'h05;
    tick();
    chk("pix05_cv", bus.pix_color_valid, 1);
    chk("pix05", bus.pix_color, 6'h36);
    bus.pix_idx = 5'h01;
    tick();
    chk("pix01_cv", bus.pix_color_valid, 1);
    chk("pix01", bus.pix_color, 6'h29);
    bus.pix_idx = 5'h11;
    tick();
    chk("pix11", bus.pix_color, 6'h16);
    bus.pix_idx = 5'h04;
    tick();
    chk("pix04_mirror", bus.pix_color, 6'h22);
    bus.pix_valid = 1'b0;
    tick();
    chk("pix_idle_cv", bus.pix_color_valid, 0);
    chk("pix_hold", bus.pix_color, 6'h22);

    build_exp();
    sweep("sweep1");

`ifdef PALETTE_GRAYSCALE_EN
    bus.pix_valid = 1'b1;
    bus.pix_idx   = 5'h01;
    bus.grayscale = 1'b1;
    tick();
    chk("gray_on", bus.pix_color, 6'h20);
    bus.grayscale = 1'b0;
    tick();
    chk("gray_off", bus.pix_color, 6'h29);
    bus.pix_valid = 1'b0;
    tick();
`endif

    // CPU write to a mirrored slot, then read it back through both ports.
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 5'h10;
    bus.cpu_wdata = 6'h0F;
    #1;
    chk("wr_ready", bus.cpu_ready, 1);
    tick();
    bus.cpu_req   = 1'b0;
    bus.pix_valid = 1'b1;
    bus.pix_idx   = 5'h00;
    chk("wr_no_rvalid", bus.cpu_rvalid, 0);
    tick();
    chk("wr_then_pix00", bus.pix_color, 6'h0F);
    bus.pix_valid = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 5'h10;
    tick();
    bus.cpu_req = 1'b0;
    chk("rd10_rvalid", bus.cpu_rvalid, 1);
    chk("rd10_data", bus.cpu_rdata, 6'h0F);
    tick();
    chk("rd10_pulse", bus.cpu_rvalid, 0);

    // Pixel pipeline holds off a pending CPU read for three cycles.
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 5'h0D;
    bus.pix_valid = 1'b1;
    bus.pix_idx   = 5'h05;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("cont_ready_low", bus.cpu_ready, 0);
      tick();
      chk("cont_no_rvalid", bus.cpu_rvalid, 0);
    end
    bus.pix_valid = 1'b0;
    #1;
    chk("cont_ready_high", bus.cpu_ready, 1);
    tick();
    bus.cpu_req = 1'b0;
    chk("cont_rvalid", bus.cpu_rvalid, 1);
    chk("cont_rdata", bus.cpu_rdata, 6'h27);
    tick();

    // Reset while a pixel response is in flight drops it.
    bus.pix_valid = 1'b1;
    bus.pix_idx   = 5'h05;
    tick();
    chk("pre_rst_cv", bus.pix_color_valid, 1);
    rst_n = 1'b0;
    #1;
    bus.pix_valid = 1'b0;
    check_reset_vals("rst_run");
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("midload_rom_addr", bus.rom_addr, 10);
    chk("midload_init_done", bus.init_done, 0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_load");
    tick();

    do_load();
    build_exp();
    chk("reload_ram0_exp", exp_ram[0], 6'h22);
    sweep("sweep2");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
